hbridge_guard: RTL and testbench

HBRIDGE_GUARD -- requirements
Module: hbridge_guard

---
 rtl/hbridge_guard_pkg.sv | 44 ++++
 rtl/hbridge_guard_channel.sv | 97 +++++++++
 rtl/hbridge_guard.sv | 112 +++++++++++
 tb/tb_hbridge_guard.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hbridge_guard_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : hbridge_guard_pkg                                      |
// | Shared stepper definitions: channel state encoding and the       |
// | drive-request decode used by every H-bridge guard channel.       |
// | Revision: 1.0  initial release                                   |
// +------------------------------------------------------------------+
package hbridge_guard_pkg;

  // Per-channel guard states.
  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_DRIVE_L = 2'd1,
    ST_DRIVE_R = 2'd2,
    ST_DEAD    = 2'd3
  } chan_state_t;

  // Raw request encoding, packed as {l, r}.
  typedef enum logic [1:0] {
    REQ_NONE    = 2'b00,
    REQ_R       = 2'b01,
    REQ_L       = 2'b10,
    REQ_ILLEGAL = 2'b11
  } req_t;

  // Decode a raw request pair; asking for both sides at once is
  // treated as asking for nothing so a bridge is never shorted.
  function automatic req_t decode_req(input logic l, input logic r);
    req_t req;
    case ({l, r})
      2'b10:   req = REQ_L;
      2'b01:   req = REQ_R;
      default: req = REQ_NONE;
    endcase
    return req;
  endfunction

  // True when a request pair would short the bridge.
  function automatic logic is_illegal(input logic l, input logic r);
    return l & r;
  endfunction

endpackage : hbridge_guard_pkg
`default_nettype wire

// File: rtl/hbridge_guard_channel.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : hbridge_guard_channel                                  |
// | One H-bridge guard: OFF / DRIVE_L / DRIVE_R / DEAD state machine |
// | with a dead-time down-counter and registered pin drives.         |
// | Revision: 1.0  initial release                                   |
// +------------------------------------------------------------------+
module hbridge_guard_channel
  import hbridge_guard_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,        // asynchronous, active-low
  input  logic                 enable,     // 0 blocks entry to / holding of DRIVE
  input  logic [CNT_WIDTH-1:0] period,     // dead-time, captured on entry to DEAD
  input  logic                 req_l,
  input  logic                 req_r,
  output logic                 drive_l,
  output logic                 drive_r,
  output logic                 next_dead   // state after this edge is DEAD
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  chan_state_t          state;
  chan_state_t          state_nxt;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] count_nxt;
  req_t                 req;

  assign req       = decode_req(req_l, req_r);
  assign next_dead = (state_nxt == ST_DEAD);

  // State, counter and pin registers; pins decode the next state so the
  // request-to-pin latency is a single cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_OFF;
      count   <= '0;
      drive_l <= 1'b0;
      drive_r <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      drive_l <= (state_nxt == ST_DRIVE_L);
      drive_r <= (state_nxt == ST_DRIVE_R);
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      ST_OFF: begin
        if (enable && req == REQ_L) begin
          state_nxt = ST_DRIVE_L;
        end else if (enable && req == REQ_R) begin
          state_nxt = ST_DRIVE_R;
        end
      end
      ST_DRIVE_L: begin
        if (!(enable && req == REQ_L)) begin
          state_nxt = ST_DEAD;
          count_nxt = period;
        end
      end
      ST_DRIVE_R: begin
        if (!(enable && req == REQ_R)) begin
          state_nxt = ST_DEAD;
          count_nxt = period;
        end
      end
      ST_DEAD: begin
        // The period was latched on entry; only the counter matters here.
        if (count == '0) begin
          if (enable && req == REQ_L) begin
            state_nxt = ST_DRIVE_L;
          end else if (enable && req == REQ_R) begin
            state_nxt = ST_DRIVE_R;
          end else begin
            state_nxt = ST_OFF;
          end
        end else begin
          count_nxt = count - CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_OFF;
        count_nxt = '0;
      end
    endcase
  end

endmodule : hbridge_guard_channel
`default_nettype wire

// File: rtl/hbridge_guard.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : hbridge_guard                                          |
// | Dual H-bridge shoot-through guard for a stepper driver. Two      |
// | independent channels insert dead time on every direction change. |
// | Option  : HBRIDGE_FAULT_LATCH_EN - sticky shoot-through fault    |
// |           that parks both bridges until i_err_clear.             |
// | Revision: 1.0  initial release                                   |
// +------------------------------------------------------------------+
module hbridge_guard
  import hbridge_guard_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,                     // asynchronous, active-low
  input  logic        i_enable,
  input  logic [31:0] i_shoot_through_period,
  input  logic        i_hbridge0_l,
  input  logic        i_hbridge0_r,
  input  logic        i_hbridge1_l,
  input  logic        i_hbridge1_r,
  input  logic        i_err_clear,
  output logic        o_hbridge0_l,
  output logic        o_hbridge0_r,
  output logic        o_hbridge1_l,
  output logic        o_hbridge1_r,
  output logic        o_busy,
  output logic        o_err_shoot_through
);

  logic illegal_any;
  logic chan_enable;
  logic dead0_nxt;
  logic dead1_nxt;

  assign illegal_any = is_illegal(i_hbridge0_l, i_hbridge0_r)
                     | is_illegal(i_hbridge1_l, i_hbridge1_r);

`ifdef HBRIDGE_FAULT_LATCH_EN
  logic fault;

  // Sticky fault flag; a fresh illegal request beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault <= 1'b0;
    end else begin
      fault <= illegal_any | (fault & ~i_err_clear);
    end
  end

  // Parking both channels acts exactly like a dropped enable, starting in
  // the very cycle the illegal request is seen.
  assign chan_enable         = i_enable & ~fault & ~illegal_any;
  assign o_err_shoot_through = fault;
`else
  logic err_pulse;
  logic unused_err_clear;

  // Non-sticky indication: one registered copy of the illegal request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= illegal_any;
    end
  end

  assign chan_enable         = i_enable;
  assign o_err_shoot_through = err_pulse;
  assign unused_err_clear    = i_err_clear;
`endif

  hbridge_guard_channel #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_bridge0 (
    .clk       (clk),
    .rst       (rst),
    .enable    (chan_enable),
    .period    (i_shoot_through_period[CNT_WIDTH-1:0]),
    .req_l     (i_hbridge0_l),
    .req_r     (i_hbridge0_r),
    .drive_l   (o_hbridge0_l),
    .drive_r   (o_hbridge0_r),
    .next_dead (dead0_nxt)
  );

  hbridge_guard_channel #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_bridge1 (
    .clk       (clk),
    .rst       (rst),
    .enable    (chan_enable),
    .period    (i_shoot_through_period[CNT_WIDTH-1:0]),
    .req_l     (i_hbridge1_l),
    .req_r     (i_hbridge1_r),
    .drive_l   (o_hbridge1_l),
    .drive_r   (o_hbridge1_r),
    .next_dead (dead1_nxt)
  );

  // Busy tracks the DEAD state of either channel, registered with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_busy <= 1'b0;
    end else begin
      o_busy <= dead0_nxt | dead1_nxt;
    end
  end

endmodule : hbridge_guard
`default_nettype wire

// File: tb/tb_hbridge_guard.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_hbridge_guard                                       |
// | Self-checking bench for hbridge_guard: directed scenarios plus   |
// | randomized requests against a dead-time countdown model.         |
// | Option  : HBRIDGE_FAULT_LATCH_EN selects the sticky-fault model. |
// | Revision: 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_hbridge_guard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_enable = 1'b0;
  logic [31:0] i_shoot_through_period = 32'd0;
  logic        i_hbridge0_l = 1'b0;
  logic        i_hbridge0_r = 1'b0;
  logic        i_hbridge1_l = 1'b0;
  logic        i_hbridge1_r = 1'b0;
  logic        i_err_clear = 1'b0;
  logic        o_hbridge0_l;
  logic        o_hbridge0_r;
  logic        o_hbridge1_l;
  logic        o_hbridge1_r;
  logic        o_busy;
  logic        o_err_shoot_through;

  int errors = 0;
  int checks = 0;

  // Model: which side each bridge shows (0 none, 1 L, 2 R) and how many
  // low "dead" cycles remain, counting the one currently on the pins.
  int     m_pin [2];
  longint m_dead[2];
  logic   m_err;

  always #5 clk = ~clk;

  hbridge_guard #(.CNT_WIDTH(32)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .i_enable               (i_enable),
    .i_shoot_through_period (i_shoot_through_period),
    .i_hbridge0_l           (i_hbridge0_l),
    .i_hbridge0_r           (i_hbridge0_r),
    .i_hbridge1_l           (i_hbridge1_l),
    .i_hbridge1_r           (i_hbridge1_r),
    .i_err_clear            (i_err_clear),
    .o_hbridge0_l           (o_hbridge0_l),
    .o_hbridge0_r           (o_hbridge0_r),
    .o_hbridge1_l           (o_hbridge1_l),
    .o_hbridge1_r           (o_hbridge1_r),
    .o_busy                 (o_busy),
    .o_err_shoot_through    (o_err_shoot_through)
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_pin[c]  = 0;
      m_dead[c] = 0;
    end
    m_err = 1'b0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_clock();
    int   want[2];
    logic ill[2];
    logic any_ill;
    logic allow;
    if (!rst) begin
      model_reset();
      return;
    end
    ill[0]  = i_hbridge0_l & i_hbridge0_r;
    ill[1]  = i_hbridge1_l & i_hbridge1_r;
    want[0] = (i_hbridge0_l && !i_hbridge0_r) ? 1 : (i_hbridge0_r && !i_hbridge0_l) ? 2 : 0;
    want[1] = (i_hbridge1_l && !i_hbridge1_r) ? 1 : (i_hbridge1_r && !i_hbridge1_l) ? 2 : 0;
    any_ill = ill[0] | ill[1];
`ifdef HBRIDGE_FAULT_LATCH_EN
    allow = i_enable && !m_err && !any_ill;
`else
    allow = i_enable;
`endif
    for (int c = 0; c < 2; c++) begin
      int w;
      w = allow ? want[c] : 0;
      if (m_dead[c] > 0) begin
        if (m_dead[c] == 1) begin
          m_dead[c] = 0;
          m_pin[c]  = w;
        end else begin
          m_dead[c] = m_dead[c] - 1;
        end
      end else if (m_pin[c] != 0) begin
        if (w != m_pin[c]) begin
          m_pin[c]  = 0;
          m_dead[c] = longint'(i_shoot_through_period) + 1;
        end
      end else begin
        m_pin[c] = w;
      end
    end
`ifdef HBRIDGE_FAULT_LATCH_EN
    m_err = any_ill | (m_err & ~i_err_clear);
`else
    m_err = any_ill;
`endif
  endtask

  task automatic check_all();
    check_bit("hb0_l", o_hbridge0_l, m_pin[0] == 1);
    check_bit("hb0_r", o_hbridge0_r, m_pin[0] == 2);
    check_bit("hb1_l", o_hbridge1_l, m_pin[1] == 1);
    check_bit("hb1_r", o_hbridge1_r, m_pin[1] == 2);
    check_bit("busy",  o_busy, (m_dead[0] > 0) || (m_dead[1] > 0));
    check_bit("err",   o_err_shoot_through, m_err);
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check_all();
  endtask

  initial begin
    int   n;
    int   nb;
    bit   b1_ok;
    int   rq0;
    int   rq1;

    // Reset state (asynchronous assertion, no clock edge needed).
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_bit("rst_hb0_l", o_hbridge0_l, 1'b0);
    check_bit("rst_busy",  o_busy, 1'b0);
    check_bit("rst_err",   o_err_shoot_through, 1'b0);
    repeat (2) step();
    rst = 1'b1;

    // Period 4: L for 10 cycles, then R -> 5 low/busy cycles.
    i_enable = 1'b1;
    i_shoot_through_period = 32'd4;
    i_hbridge0_l = 1'b1;
    step();
    check_bit("latency_l", o_hbridge0_l, 1'b1);
    repeat (9) step();
    i_hbridge0_l = 1'b0;
    i_hbridge0_r = 1'b1;
    n = 0; nb = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (o_hbridge0_r) break;
      if (!o_hbridge0_l && !o_hbridge0_r) n++;
      if (o_busy) nb++;
    end
    check_int("dead_len_p4", n, 5);
    check_int("busy_len_p4", nb, 5);
    check_bit("drive_r_after_dead", o_hbridge0_r, 1'b1);

    // Period 0 reversals with bridge1 held on L.
    i_hbridge1_l = 1'b1;
    repeat (2) step();
    i_shoot_through_period = 32'd0;
    b1_ok = 1'b1;
    i_hbridge0_r = 1'b0;
    i_hbridge0_l = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (o_hbridge1_l !== 1'b1 || o_hbridge1_r !== 1'b0) b1_ok = 1'b0;
      if (o_hbridge0_l) break;
      n++;
    end
    check_int("dead_len_p0_rl", n, 1);
    repeat (3) step();
    i_hbridge0_l = 1'b0;
    i_hbridge0_r = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (o_hbridge1_l !== 1'b1 || o_hbridge1_r !== 1'b0) b1_ok = 1'b0;
      if (o_hbridge0_r) break;
      n++;
    end
    check_int("dead_len_p0_lr", n, 1);
    check_bit("bridge1_steady", b1_ok, 1'b1);

    // Period 10, changed to 2 during DEAD -> still 11 dead cycles.
    i_shoot_through_period = 32'd10;
    i_hbridge0_r = 1'b0;
    i_hbridge0_l = 1'b1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (o_hbridge0_l) break;
      n++;
      if (n == 3) i_shoot_through_period = 32'd2;
    end
    check_int("dead_len_p10", n, 11);

    // Enable drop while both drive: DEAD (3 cycles at period 2), then OFF.
    i_enable = 1'b0;
    step();
    check_bit("dis_hb0_l", o_hbridge0_l, 1'b0);
    check_bit("dis_hb1_l", o_hbridge1_l, 1'b0);
    check_bit("dis_busy",  o_busy, 1'b1);
    repeat (2) step();
    step();
    check_bit("dis_busy_end", o_busy, 1'b0);
    repeat (3) step();
    check_bit("dis_off_hb0", o_hbridge0_l, 1'b0);
    check_bit("dis_off_hb1", o_hbridge1_l, 1'b0);
    i_enable = 1'b1;
    step();
    check_bit("reen_hb0_l", o_hbridge0_l, 1'b1);
    check_bit("reen_hb1_l", o_hbridge1_l, 1'b1);

    // Illegal request on bridge1.
    i_hbridge1_r = 1'b1;
    step();
    check_bit("ill_err",   o_err_shoot_through, 1'b1);
    check_bit("ill_hb1_l", o_hbridge1_l, 1'b0);
    check_bit("ill_hb1_r", o_hbridge1_r, 1'b0);
    i_hbridge1_r = 1'b0;
    step();
`ifdef HBRIDGE_FAULT_LATCH_EN
    check_bit("ill_err_sticky", o_err_shoot_through, 1'b1);
    repeat (6) step();
    check_bit("fault_hb0_l", o_hbridge0_l, 1'b0);
    check_bit("fault_hb1_l", o_hbridge1_l, 1'b0);
    check_bit("fault_err",   o_err_shoot_through, 1'b1);
    i_err_clear  = 1'b1;
    i_hbridge1_r = 1'b1;
    step();
    check_bit("set_wins", o_err_shoot_through, 1'b1);
    i_hbridge1_r = 1'b0;
    step();
    i_err_clear = 1'b0;
    check_bit("err_cleared", o_err_shoot_through, 1'b0);
    repeat (5) step();
    check_bit("resume_hb0_l", o_hbridge0_l, 1'b1);
    check_bit("resume_hb1_l", o_hbridge1_l, 1'b1);
`else
    check_bit("ill_err_pulse", o_err_shoot_through, 1'b0);
    i_err_clear = 1'b1;
    repeat (6) step();
    i_err_clear = 1'b0;
    check_bit("resume_hb1_l", o_hbridge1_l, 1'b1);
    check_bit("resume_hb0_l", o_hbridge0_l, 1'b1);
`endif

    // Asynchronous reset while driving R.
    i_hbridge0_l = 1'b0;
    i_hbridge0_r = 1'b1;
    repeat (8) step();
    check_bit("pre_rst_hb0_r", o_hbridge0_r, 1'b1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_bit("arst_hb0_r", o_hbridge0_r, 1'b0);
    check_bit("arst_hb1_l", o_hbridge1_l, 1'b0);
    check_bit("arst_busy",  o_busy, 1'b0);
    step();
    i_hbridge0_r = 1'b0;
    i_hbridge0_l = 1'b1;
    rst = 1'b1;
    step();
    check_bit("l_after_release", o_hbridge0_l, 1'b1);
    check_bit("no_dead_after_release", o_busy, 1'b0);

    // Randomized requests against the model.
    rq0 = 1;
    rq1 = 1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) < 15) rq0 = $urandom_range(0, 2);
      if ($urandom_range(0, 99) < 15) rq1 = $urandom_range(0, 2);
      i_hbridge0_l = (rq0 == 1);
      i_hbridge0_r = (rq0 == 2);
      i_hbridge1_l = (rq1 == 1);
      i_hbridge1_r = (rq1 == 2);
      if ($urandom_range(0, 39) == 0) begin
        i_hbridge0_l = 1'b1;
        i_hbridge0_r = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) begin
        i_hbridge1_l = 1'b1;
        i_hbridge1_r = 1'b1;
      end
      if ($urandom_range(0, 99) < 5) i_enable = ~i_enable;
      if ($urandom_range(0, 99) < 10) i_shoot_through_period = 32'($urandom_range(0, 5));
      i_err_clear = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_hbridge_guard
`default_nettype wire
